alu_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the shared 32-bit combinational ALU.
- Accepts one operation at a time over valid/ready, holds the operands in registers and drives them to the ALU for one execute cycle.
- Captures the ALU result and zero flag, then returns them to the winning requester over valid/ready.
- Sits between the core issue logic (port 0) and the address/auxiliary unit (port 1) and a single ALU instance outside this block.

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin sequencer in front of one shared ALU.
// One operation in flight: IDLE accepts, EXEC drives the ALU, RESP returns.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zf,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_dataOut,
    input  logic             alu_zf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [OPW-1:0] OP_AND = OPW'(0);
    localparam logic [OPW-1:0] OP_OR  = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(6);
    localparam logic [OPW-1:0] OP_SLT = OPW'(7);
    localparam logic [OPW-1:0] OP_NOR = OPW'(12);

    state_t           r_state;
    logic             r_last_grant;
    logic             r_owner;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_data;
    logic             r_zf;
    logic             r_err;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic             r_busy;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;
    logic w_accept;
    logic w_rsp_done;
    logic w_legal;

    assign w_idle = (r_state == S_IDLE);

    // On contention the port that did not complete last wins.
    assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
    assign w_accept = w_idle & (w_grant0 | w_grant1);

    assign w_rsp_done = (r_rsp0_valid & rsp0_ready)
                      | (r_rsp1_valid & rsp1_ready);

    always_comb begin
        case (r_op)
            OP_AND, OP_OR, OP_ADD,
            OP_SUB, OP_SLT, OP_NOR: w_legal = 1'b1;
            default:                w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_data       <= '0;
            r_zf         <= 1'b0;
            r_err        <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant1;
                        r_op    <= w_grant1 ? req1_op : req0_op;
                        r_a     <= w_grant1 ? req1_a  : req0_a;
                        r_b     <= w_grant1 ? req1_b  : req0_b;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_data       <= alu_dataOut;
                    r_zf         <= alu_zf;
                    r_err        <= ~w_legal;
                    r_rsp0_valid <= ~r_owner;
                    r_rsp1_valid <= r_owner;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_done) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_last_grant <= r_owner;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_idle & w_grant0;
    assign req1_ready = w_idle & w_grant1;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_data   = r_data;
    assign rsp_zf     = r_zf;
    assign rsp_err    = r_err;
    assign alu_data1  = r_a;
    assign alu_data2  = r_b;
    assign alu_op     = r_op;
    assign busy       = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives both request ports against a behavioural ALU
// and an abstract round-robin model of who should win each operation.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [3:0]  req0_op, req1_op, alu_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] rsp_data, alu_data1, alu_data2, alu_dataOut;
    logic        rsp_zf, rsp_err, alu_zf, busy;

    int n_cmp = 0;
    int n_err = 0;
    int m_last;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
        .alu_dataOut(alu_dataOut), .alu_zf(alu_zf), .busy(busy)
    );

    // Behavioural ALU: {zf, result}; unknown ops yield 0 with zf=1.
    function automatic logic [32:0] alu_model(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd6:    r = a - b;
            4'd7:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   r = ~(a | b);
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    assign {alu_zf, alu_dataOut} = alu_model(alu_op, alu_data1, alu_data2);

    function automatic bit op_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    endfunction

    function automatic int model_winner(input bit v0, input bit v1,
                                        input int last);
        if (v0 && v1) return (last == 0) ? 1 : 0;
        return v1 ? 1 : 0;
    endfunction

    task automatic run_op(input bit v0, input bit v1,
                          input logic [3:0] op0, input logic [31:0] a0,
                          input logic [31:0] b0,
                          input logic [3:0] op1, input logic [31:0] a1,
                          input logic [31:0] b1,
                          input int hold,
                          output int win, output int lat,
                          output logic [31:0] d, output logic zf,
                          output logic er, output bit stable,
                          output bit released, output bit dual);
        win = -1; lat = 0; d = '0; zf = 0; er = 0;
        stable = 1; released = 0; dual = 0;
        @(negedge clk);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready && req1_ready) dual = 1;
            if (req0_ready) begin win = 0; break; end
            if (req1_ready) begin win = 1; break; end
            @(negedge clk);
        end
        if (win < 0) begin
            req0_valid = 0; req1_valid = 0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        lat = 1;
        while (lat < 20) begin
            #1;
            if (win == 0 ? rsp0_valid : rsp1_valid) break;
            lat++;
            @(negedge clk);
        end
        if (lat >= 20) return;
        d = rsp_data; zf = rsp_zf; er = rsp_err;
        if ((win == 0 ? rsp1_valid : rsp0_valid) || !busy) stable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            if (rsp_data !== d || rsp_zf !== zf || rsp_err !== er ||
                !(win == 0 ? rsp0_valid : rsp1_valid)) stable = 0;
        end
        if (win == 0) rsp0_ready = 1; else rsp1_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0;
        #1;
        released = !rsp0_valid && !rsp1_valid && !busy;
    endtask

    task automatic test_reset;
        logic [106:0] v;
        rst_n = 0;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0; rsp0_ready = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0; rsp1_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        v = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
             rsp_zf, rsp_err, alu_data1, alu_data2, alu_op, busy};
        n_cmp++;
        if (v !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h want=0", v);
        end
        @(negedge clk);
        rst_n = 1;
        m_last = 1;
    endtask

    task automatic test_add;
        int w, l; logic [31:0] d; logic z, e; bit s, r, du;
        run_op(1, 0, 4'd2, 32'd5, 32'd7, 4'd0, 0, 0, 0,
               w, l, d, z, e, s, r, du);
        n_cmp++;
        if (w !== 0) begin n_err++; $display("FAIL add_grant got=%0d want=0", w); end
        n_cmp++;
        if (l !== 2) begin n_err++; $display("FAIL add_latency got=%0d want=2", l); end
        n_cmp++;
        if ({e, z, d} !== {2'b00, 32'd12}) begin
            n_err++;
            $display("FAIL add_result got=%b/%b/%h want=0/0/0000000c", e, z, d);
        end
        n_cmp++;
        if (!r) begin n_err++; $display("FAIL add_release got=%0d want=1", r); end
        m_last = 0;
    endtask

    task automatic test_hold;
        int w, l; logic [31:0] d; logic z, e; bit s, r, du;
        run_op(0, 1, 4'd0, 0, 0, 4'd6, 32'd9, 32'd9, 4,
               w, l, d, z, e, s, r, du);
        n_cmp++;
        if (w !== 1) begin n_err++; $display("FAIL hold_grant got=%0d want=1", w); end
        n_cmp++;
        if ({e, z, d} !== {2'b01, 32'd0}) begin
            n_err++;
            $display("FAIL hold_result got=%b/%b/%h want=0/1/00000000", e, z, d);
        end
        n_cmp++;
        if (!s) begin n_err++; $display("FAIL hold_stable got=%0d want=1", s); end
        n_cmp++;
        if (!r) begin n_err++; $display("FAIL hold_release got=%0d want=1", r); end
        m_last = 1;
    endtask

    task automatic test_alternate;
        int g[$];
        logic [32:0] rs[$];
        int want_g[4] = '{0, 1, 0, 1};
        @(negedge clk);
        req0_valid = 1; req0_op = 4'd7;  req0_a = 32'd3; req0_b = 32'd4;
        req1_valid = 1; req1_op = 4'd12; req1_a = 32'd0; req1_b = 32'd0;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req0_ready) g.push_back(0);
            if (req1_ready) g.push_back(1);
            if (rsp0_valid) rs.push_back({1'b0, rsp_data});
            if (rsp1_valid) rs.push_back({1'b1, rsp_data});
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        n_cmp++;
        if (g.size() != 4 || rs.size() != 4) begin
            n_err++;
            $display("FAIL alt_count got=%0d/%0d want=4/4", g.size(), rs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (g[i] !== want_g[i]) begin
                    n_err++;
                    $display("FAIL alt_grant[%0d] got=%0d want=%0d", i, g[i], want_g[i]);
                end
                n_cmp++;
                if (rs[i] !== ((i % 2 == 0) ? {1'b0, 32'd1} : {1'b1, 32'hFFFFFFFF})) begin
                    n_err++;
                    $display("FAIL alt_rsp[%0d] got=%h", i, rs[i]);
                end
            end
        end
        m_last = 1;
    endtask

    task automatic test_illegal;
        int w, l; logic [31:0] d; logic z, e; bit s, r, du;
        run_op(1, 0, 4'd3, 32'd1, 32'd1, 4'd0, 0, 0, 1,
               w, l, d, z, e, s, r, du);
        n_cmp++;
        if ({w == 0, e, z, d} !== {3'b111, 32'd0}) begin
            n_err++;
            $display("FAIL illegal got=w%0d/%b/%b/%h want=w0/1/1/00000000", w, e, z, d);
        end
        m_last = 0;
    endtask

    task automatic test_reset_exec;
        logic [106:0] v;
        bit seen_ready, leak;
        int w, l; logic [31:0] d; logic z, e; bit s, r, du;
        @(negedge clk);
        req1_valid = 1; req1_op = 4'd2; req1_a = 32'd1; req1_b = 32'd2;
        #1;
        seen_ready = req1_ready;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 0;
        #1;
        n_cmp++;
        if (!seen_ready || !busy) begin
            n_err++;
            $display("FAIL rexec_setup got=%0d/%0d want=1/1", seen_ready, busy);
        end
        rst_n = 0;
        #1;
        v = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
             rsp_zf, rsp_err, alu_data1, alu_data2, alu_op, busy};
        n_cmp++;
        if (v !== '0) begin
            n_err++;
            $display("FAIL rexec_outputs got=%h want=0", v);
        end
        @(negedge clk);
        rst_n = 1;
        leak = 0;
        repeat (5) begin
            @(negedge clk); #1;
            if (rsp0_valid || rsp1_valid || busy) leak = 1;
        end
        n_cmp++;
        if (leak) begin n_err++; $display("FAIL rexec_no_rsp got=1 want=0"); end
        m_last = 1;
        run_op(1, 1, 4'd0, 32'hF0, 32'h3C, 4'd1, 32'h1, 32'h2, 0,
               w, l, d, z, e, s, r, du);
        n_cmp++;
        if (w !== 0 || d !== 32'h30) begin
            n_err++;
            $display("FAIL rexec_next got=w%0d/%h want=w0/00000030", w, d);
        end
        m_last = 0;
    endtask

    task automatic test_busy_pulse;
        bit acc, bad0, got1, leak;
        logic [31:0] d;
        acc = 0; bad0 = 0; got1 = 0; leak = 0; d = '0;
        @(negedge clk);
        req1_valid = 1; req1_op = 4'd1; req1_a = 32'd1; req1_b = 32'd2;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (req1_ready) begin acc = 1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 0;
        req0_valid = 1; req0_op = 4'd2; req0_a = 32'd5; req0_b = 32'd5;
        #1;
        if (req0_ready) bad0 = 1;
        @(negedge clk);
        req0_valid = 0;
        #1;
        got1 = rsp1_valid && !rsp0_valid;
        d = rsp_data;
        rsp1_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp1_ready = 0;
        repeat (4) begin
            #1;
            if (rsp0_valid || busy || req0_ready) leak = 1;
            @(negedge clk);
        end
        n_cmp++;
        if (!acc || bad0) begin
            n_err++;
            $display("FAIL pulse_accept got=acc%0d/r0_%0d want=acc1/r0_0", acc, bad0);
        end
        n_cmp++;
        if (!got1 || d !== 32'd3) begin
            n_err++;
            $display("FAIL pulse_rsp1 got=%0d/%h want=1/00000003", got1, d);
        end
        n_cmp++;
        if (leak) begin n_err++; $display("FAIL pulse_no_rsp0 got=1 want=0"); end
        m_last = 1;
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            int sel, ew, w, l, hold;
            bit v0, v1, s, r, du;
            logic [3:0] op0, op1, eop;
            logic [31:0] a0, b0, a1, b1, ea, eb, d;
            logic z, e;
            logic [32:0] exp;
            sel = $urandom_range(0, 2);
            v0 = (sel != 1); v1 = (sel != 0);
            op0 = 4'($urandom_range(0, 15)); op1 = 4'($urandom_range(0, 15));
            a0 = $urandom; a1 = $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            hold = $urandom_range(0, 2);
            ew = model_winner(v0, v1, m_last);
            eop = (ew == 0) ? op0 : op1;
            ea = (ew == 0) ? a0 : a1;
            eb = (ew == 0) ? b0 : b1;
            exp = alu_model(eop, ea, eb);
            run_op(v0, v1, op0, a0, b0, op1, a1, b1, hold,
                   w, l, d, z, e, s, r, du);
            n_cmp++;
            if (w !== ew || du) begin
                n_err++;
                $display("FAIL rnd%0d_grant got=%0d dual=%0d want=%0d", it, w, du, ew);
            end
            n_cmp++;
            if (l !== 2) begin
                n_err++;
                $display("FAIL rnd%0d_latency got=%0d want=2", it, l);
            end
            n_cmp++;
            if ({e, z, d} !== {!op_legal(eop), exp}) begin
                n_err++;
                $display("FAIL rnd%0d_result got=%b/%b/%h want=%b/%b/%h",
                         it, e, z, d, !op_legal(eop), exp[32], exp[31:0]);
            end
            n_cmp++;
            if (!s || !r) begin
                n_err++;
                $display("FAIL rnd%0d_handshake got=%0d/%0d want=1/1", it, s, r);
            end
            m_last = ew;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_hold();
        test_alternate();
        test_illegal();
        test_reset_exec();
        test_busy_pulse();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
